// File: rtl/ex_operand_resolve_hold.sv
// EX-stage operand resolution: two-operand forwarding, load-use detection, hold-under-stall, valid/ready to ALU.
// Optional FWD_STATS_EN macro adds forwarded-operand and stall-cycle counters.
module ex_operand_resolve_hold #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_FWD    = 2,
    parameter int REG_AW     = 5
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          flush,
    input  logic                          in_valid,
    input  logic                          use_rs1,
    input  logic                          use_rs2,
    input  logic [REG_AW-1:0]             rs1_addr,
    input  logic [REG_AW-1:0]             rs2_addr,
    input  logic [DATA_WIDTH-1:0]         rd1_reg,
    input  logic [DATA_WIDTH-1:0]         rd2_reg,
    input  logic [NUM_FWD-1:0]            fwd_valid,
    input  logic [NUM_FWD-1:0]            fwd_pending,
    input  logic [NUM_FWD*REG_AW-1:0]     fwd_rd,
    input  logic [NUM_FWD*DATA_WIDTH-1:0] fwd_data,
    input  logic [1:0]                    alu_sel_rs1,
    input  logic [1:0]                    alu_sel_rs2,
    input  logic [DATA_WIDTH-1:0]         pc,
    input  logic [DATA_WIDTH-1:0]         imm,
    input  logic                          alu_ready,
    output logic                          out_valid,
    output logic [DATA_WIDTH-1:0]         op_a,
    output logic [DATA_WIDTH-1:0]         op_b,
    output logic [DATA_WIDTH-1:0]         store_data,
    output logic                          stall_req,
    output logic [31:0]                   fwd_count,
    output logic [31:0]                   stall_count,
    output logic [1:0]                    fsm_state
);

    // Handshake: a transfer (fire) happens in a cycle where out_valid && alu_ready;
    // out_valid never waits on alu_ready, and operands stay stable until fire.
    typedef enum logic [1:0] {
        EMPTY     = 2'd0,
        WAIT_OPND = 2'd1,
        WAIT_ALU  = 2'd2
    } state_t;

    state_t                  state;
    logic                    m1, p1, m2, p2;
    logic [DATA_WIDTH-1:0]   d1, d2;
    logic                    hold1_v, hold2_v;
    logic [DATA_WIDTH-1:0]   hold1_d, hold2_d;
    logic                    res1, res2, opnd_ok, ov_int, fire;
    logic [DATA_WIDTH-1:0]   val1, val2, a_mux, b_mux;

    // Scan from lowest priority up so the youngest matching source overwrites.
    always_comb begin
        m1 = 1'b0; p1 = 1'b0; d1 = rd1_reg;
        m2 = 1'b0; p2 = 1'b0; d2 = rd2_reg;
        for (int i = NUM_FWD - 1; i >= 0; i--) begin
            if (fwd_valid[i] && fwd_rd[i*REG_AW +: REG_AW] == rs1_addr && rs1_addr != '0) begin
                m1 = 1'b1;
                p1 = fwd_pending[i];
                d1 = fwd_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
            if (fwd_valid[i] && fwd_rd[i*REG_AW +: REG_AW] == rs2_addr && rs2_addr != '0) begin
                m2 = 1'b1;
                p2 = fwd_pending[i];
                d2 = fwd_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign res1    = !use_rs1 || hold1_v || !(m1 && p1);
    assign res2    = !use_rs2 || hold2_v || !(m2 && p2);
    assign val1    = hold1_v ? hold1_d : d1;
    assign val2    = hold2_v ? hold2_d : d2;
    assign opnd_ok = res1 && res2;
    assign ov_int  = in_valid && !flush && opnd_ok;
    assign fire    = ov_int && alu_ready;

    always_comb begin
        a_mux = '0;
        case (alu_sel_rs1)
            2'd0:    a_mux = val1;
            2'd1:    a_mux = pc;
            default: a_mux = '0;
        endcase
        b_mux = '0;
        case (alu_sel_rs2)
            2'd0:    b_mux = val2;
            2'd1:    b_mux = imm;
            2'd2:    b_mux = DATA_WIDTH'(4);
            default: b_mux = '0;
        endcase
    end

    assign out_valid  = rst_n && ov_int;
    assign stall_req  = rst_n && in_valid && !flush && !fire;
    assign op_a       = rst_n ? a_mux : '0;
    assign op_b       = rst_n ? b_mux : '0;
    assign store_data = rst_n ? val2 : '0;
    assign fsm_state  = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold1_v <= 1'b0;
            hold2_v <= 1'b0;
            hold1_d <= '0;
            hold2_d <= '0;
        end else if (fire || flush || !in_valid) begin
            hold1_v <= 1'b0;
            hold2_v <= 1'b0;
        end else begin
            if (!hold1_v && res1) begin
                hold1_v <= 1'b1;
                hold1_d <= d1;
            end
            if (!hold2_v && res2) begin
                hold2_v <= 1'b1;
                hold2_d <= d2;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
        end else if (fire || flush || !in_valid) begin
            state <= EMPTY;
        end else if (opnd_ok) begin
            state <= WAIT_ALU;
        end else begin
            state <= WAIT_OPND;
        end
    end

`ifdef FWD_STATS_EN
    logic hold1_f, hold2_f, fw1, fw2;

    // Remember whether a held operand originally came from a forwarding source.
    assign fw1 = use_rs1 && (hold1_v ? hold1_f : m1);
    assign fw2 = use_rs2 && (hold2_v ? hold2_f : m2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold1_f     <= 1'b0;
            hold2_f     <= 1'b0;
            fwd_count   <= '0;
            stall_count <= '0;
        end else begin
            if (!hold1_v) hold1_f <= m1;
            if (!hold2_v) hold2_f <= m2;
            if (fire) fwd_count <= fwd_count + {31'b0, fw1} + {31'b0, fw2};
            if (stall_req) stall_count <= stall_count + 32'd1;
        end
    end
`else
    assign fwd_count   = '0;
    assign stall_count = '0;
`endif

endmodule

// File: tb/tb_ex_operand_resolve_hold.sv
// Bench for ex_operand_resolve_hold: directed vectors, behavioural model compared every cycle,
// plus literal expectations from the test plan.
module tb_ex_operand_resolve_hold;

    localparam int DW = 32;
    localparam int NF = 2;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          flush, in_valid, use_rs1, use_rs2, alu_ready;
    logic [AW-1:0] rs1_addr, rs2_addr;
    logic [DW-1:0] rd1_reg, rd2_reg, pc, imm;
    logic [NF-1:0] fwd_valid, fwd_pending;
    logic [NF*AW-1:0] fwd_rd;
    logic [NF*DW-1:0] fwd_data;
    logic [1:0]    alu_sel_rs1, alu_sel_rs2;
    logic          out_valid, stall_req;
    logic [DW-1:0] op_a, op_b, store_data;
    logic [31:0]   fwd_count, stall_count;
    logic [1:0]    fsm_state;

    int n_checks = 0;
    int n_err = 0;

    ex_operand_resolve_hold #(.DATA_WIDTH(DW), .NUM_FWD(NF), .REG_AW(AW)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
        .use_rs1(use_rs1), .use_rs2(use_rs2), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rd1_reg(rd1_reg), .rd2_reg(rd2_reg), .fwd_valid(fwd_valid), .fwd_pending(fwd_pending),
        .fwd_rd(fwd_rd), .fwd_data(fwd_data), .alu_sel_rs1(alu_sel_rs1), .alu_sel_rs2(alu_sel_rs2),
        .pc(pc), .imm(imm), .alu_ready(alu_ready), .out_valid(out_valid), .op_a(op_a),
        .op_b(op_b), .store_data(store_data), .stall_req(stall_req), .fwd_count(fwd_count),
        .stall_count(stall_count), .fsm_state(fsm_state)
    );

    // Clock
    always #5 clk = ~clk;

    // Behavioural model: operands captured for the current instruction, plus counters.
    logic          cap_v [2] = '{1'b0, 1'b0};
    logic [DW-1:0] cap_d [2] = '{32'd0, 32'd0};
    logic          cap_f [2] = '{1'b0, 1'b0};
    logic [1:0]    m_state = 2'd0;
    logic [31:0]   m_fwd = 32'd0;
    logic [31:0]   m_stall = 32'd0;

    typedef struct packed {
        logic          ov, sr, fire, ok1, ok2;
        logic [DW-1:0] a, b, sd, live1, live2;
        logic          lf1, lf2;
        logic [1:0]    nfwd;
    } exp_t;

    // First source in priority order naming the register decides; x0 reads the register file.
    function automatic void lookup(input logic [AW-1:0] addr, input logic [DW-1:0] rf,
                                   output logic [DW-1:0] val, output logic pend, output logic from_fwd);
        val = rf; pend = 1'b0; from_fwd = 1'b0;
        if (addr != 0) begin
            for (int s = 0; s < NF; s++) begin
                if (!from_fwd && fwd_valid[s] && fwd_rd[s*AW +: AW] == addr) begin
                    from_fwd = 1'b1;
                    pend = fwd_pending[s];
                    val = fwd_data[s*DW +: DW];
                end
            end
        end
    endfunction

    function automatic exp_t model_eval();
        exp_t e;
        logic lp1, lp2;
        logic [DW-1:0] v1, v2;
        logic f1, f2;
        lookup(rs1_addr, rd1_reg, e.live1, lp1, e.lf1);
        lookup(rs2_addr, rd2_reg, e.live2, lp2, e.lf2);
        e.ok1 = !use_rs1 || cap_v[0] || !lp1;
        e.ok2 = !use_rs2 || cap_v[1] || !lp2;
        v1 = cap_v[0] ? cap_d[0] : e.live1;
        v2 = cap_v[1] ? cap_d[1] : e.live2;
        f1 = use_rs1 && (cap_v[0] ? cap_f[0] : e.lf1);
        f2 = use_rs2 && (cap_v[1] ? cap_f[1] : e.lf2);
        e.nfwd = {1'b0, f1} + {1'b0, f2};
        e.ov = in_valid && !flush && e.ok1 && e.ok2;
        e.fire = e.ov && alu_ready;
        e.sr = in_valid && !flush && !e.fire;
        e.a = (alu_sel_rs1 == 0) ? v1 : (alu_sel_rs1 == 1) ? pc : 32'd0;
        e.b = (alu_sel_rs2 == 0) ? v2 : (alu_sel_rs2 == 1) ? imm : (alu_sel_rs2 == 2) ? 32'd4 : 32'd0;
        e.sd = v2;
        if (!rst_n) begin
            e.ov = 1'b0; e.sr = 1'b0; e.fire = 1'b0;
            e.a = '0; e.b = '0; e.sd = '0;
        end
        return e;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        exp_t e;
        if (!rst_n) begin
            cap_v[0] = 1'b0; cap_v[1] = 1'b0;
            cap_d[0] = '0;   cap_d[1] = '0;
            m_state = 2'd0; m_fwd = 32'd0; m_stall = 32'd0;
        end else begin
            e = model_eval();
            if (e.sr) m_stall = m_stall + 32'd1;
            if (e.fire) m_fwd = m_fwd + 32'(e.nfwd);
            if (!in_valid || flush || e.fire) begin
                cap_v[0] = 1'b0; cap_v[1] = 1'b0;
                m_state = 2'd0;
            end else begin
                if (!cap_v[0] && e.ok1) begin cap_v[0] = 1'b1; cap_d[0] = e.live1; cap_f[0] = e.lf1; end
                if (!cap_v[1] && e.ok2) begin cap_v[1] = 1'b1; cap_d[1] = e.live2; cap_f[1] = e.lf2; end
                m_state = (e.ok1 && e.ok2) ? 2'd2 : 2'd1;
            end
        end
    end

    // Scoreboard check
    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Compare process: every mid-cycle point
    always @(negedge clk) begin
        exp_t e;
        e = model_eval();
        chk("m_out_valid", {31'b0, out_valid}, {31'b0, e.ov});
        chk("m_stall_req", {31'b0, stall_req}, {31'b0, e.sr});
        chk("m_op_a", op_a, e.a);
        chk("m_op_b", op_b, e.b);
        chk("m_store_data", store_data, e.sd);
        chk("m_fsm_state", {30'b0, fsm_state}, {30'b0, m_state});
`ifdef FWD_STATS_EN
        chk("m_fwd_count", fwd_count, m_fwd);
        chk("m_stall_count", stall_count, m_stall);
`else
        chk("m_fwd_count", fwd_count, 32'd0);
        chk("m_stall_count", stall_count, 32'd0);
`endif
    end

    // Driver tasks
    task automatic set_fwd(input int s, input logic v, input logic p, input logic [AW-1:0] rd,
                           input logic [DW-1:0] d);
        fwd_valid[s] = v;
        fwd_pending[s] = p;
        fwd_rd[s*AW +: AW] = rd;
        fwd_data[s*DW +: DW] = d;
    endtask

    task automatic set_idle();
        flush = 0; in_valid = 0; use_rs1 = 0; use_rs2 = 0; alu_ready = 1;
        rs1_addr = 0; rs2_addr = 0; rd1_reg = 0; rd2_reg = 0;
        fwd_valid = 0; fwd_pending = 0; fwd_rd = 0; fwd_data = 0;
        alu_sel_rs1 = 0; alu_sel_rs2 = 0; pc = 32'h1000; imm = 32'h20;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [1:0]  tbl_s1 [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
    logic [1:0]  tbl_s2 [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
    logic [31:0] tbl_a  [4] = '{32'h1000, 32'h0, 32'h0, 32'hA1};
    logic [31:0] tbl_b  [4] = '{32'h20, 32'h4, 32'h0, 32'hB2};

    initial begin
        set_idle();
        #1 rst_n = 0;
        @(negedge clk);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_fsm", {30'b0, fsm_state}, 32'd0);
        chk("rst_fwd_count", fwd_count, 32'd0);
        chk("rst_stall_count", stall_count, 32'd0);
        #2 rst_n = 1;
        step();

        // Priority: youngest source wins
        in_valid = 1; use_rs1 = 1; rs1_addr = 5; rd1_reg = 32'h0BAD;
        set_fwd(0, 1, 0, 5, 32'h11); set_fwd(1, 1, 0, 5, 32'h22);
        @(negedge clk);
        chk("prio_op_a", op_a, 32'h11);
        chk("prio_valid", {31'b0, out_valid}, 32'd1);
        chk("prio_stall", {31'b0, stall_req}, 32'd0);
        step();

        // x0 never forwards
        rs1_addr = 0; rd1_reg = 32'h1234;
        set_fwd(0, 1, 0, 0, 32'hFF); set_fwd(1, 0, 0, 0, 0);
        @(negedge clk);
        chk("x0_op_a", op_a, 32'h1234);
        chk("x0_stall", {31'b0, stall_req}, 32'd0);
        step();

        // Load-use on rs2
        use_rs1 = 0; use_rs2 = 1; rs2_addr = 7; rd2_reg = 32'h0BAD;
        set_fwd(0, 1, 1, 7, 32'h0); set_fwd(1, 0, 0, 0, 0);
        @(negedge clk);
        chk("lu_stall", {31'b0, stall_req}, 32'd1);
        chk("lu_valid", {31'b0, out_valid}, 32'd0);
        step();
        set_fwd(0, 0, 0, 0, 0); set_fwd(1, 1, 0, 7, 32'hABCD);
        @(negedge clk);
        chk("lu_op_b", op_b, 32'hABCD);
        chk("lu_store", store_data, 32'hABCD);
        chk("lu_fire", {31'b0, out_valid}, 32'd1);
        step();

        // Hold while downstream busy and forward source retires
        use_rs2 = 0; use_rs1 = 1; rs1_addr = 3; rd1_reg = 32'h99; alu_ready = 0;
        set_fwd(0, 1, 0, 3, 32'h55); set_fwd(1, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("hold_op_a", op_a, 32'h55);
            chk("hold_stall", {31'b0, stall_req}, 32'd1);
            step();
            set_fwd(0, 0, 0, 0, 0);
        end
        alu_ready = 1;
        @(negedge clk);
        chk("hold_fire_op_a", op_a, 32'h55);
        chk("hold_fire_stall", {31'b0, stall_req}, 32'd0);
        step();

        // Flush in WAIT_ALU
        rs1_addr = 4; alu_ready = 0;
        set_fwd(0, 1, 0, 4, 32'h5A);
        @(negedge clk);
        step();
        set_fwd(0, 0, 0, 0, 0); flush = 1;
        @(negedge clk);
        chk("flush_fsm", {30'b0, fsm_state}, 32'd2);
        chk("flush_valid", {31'b0, out_valid}, 32'd0);
        chk("flush_stall", {31'b0, stall_req}, 32'd0);
        step();
        flush = 0; rd1_reg = 32'h77; alu_ready = 1;
        @(negedge clk);
        chk("flush_fresh_op_a", op_a, 32'h77);
        step();

        // Operand select table
        use_rs1 = 1; use_rs2 = 1; rs1_addr = 1; rs2_addr = 2; rd1_reg = 32'hA1; rd2_reg = 32'hB2;
        for (int k = 0; k < 4; k++) begin
            alu_sel_rs1 = tbl_s1[k]; alu_sel_rs2 = tbl_s2[k];
            @(negedge clk);
            chk("sel_op_a", op_a, tbl_a[k]);
            chk("sel_op_b", op_b, tbl_b[k]);
            chk("sel_store", store_data, 32'hB2);
            step();
        end

        // Same source for both operands; pending older source ignored
        rs1_addr = 9; rs2_addr = 9;
        set_fwd(0, 1, 0, 9, 32'hD4); set_fwd(1, 1, 1, 9, 32'hC3);
        @(negedge clk);
        chk("both_op_a", op_a, 32'hD4);
        chk("both_op_b", op_b, 32'hD4);
        chk("both_valid", {31'b0, out_valid}, 32'd1);
        step();

        // Reset during WAIT_OPND
        use_rs1 = 0; rs2_addr = 7; alu_sel_rs2 = 1;
        set_fwd(0, 1, 1, 7, 32'h0); set_fwd(1, 0, 0, 0, 0);
        @(negedge clk);
        step();
        chk("pre_rst_fsm", {30'b0, fsm_state}, 32'd1);
        chk("pre_rst_stall", {31'b0, stall_req}, 32'd1);
        #1 rst_n = 0;
        #1;
        chk("rst_mid_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_mid_stall", {31'b0, stall_req}, 32'd0);
        chk("rst_mid_op_b", op_b, 32'd0);
        chk("rst_mid_store", store_data, 32'd0);
        chk("rst_mid_fsm", {30'b0, fsm_state}, 32'd0);
        chk("rst_mid_fwd_count", fwd_count, 32'd0);
        chk("rst_mid_stall_count", stall_count, 32'd0);
        @(negedge clk);
        step();
        #2 rst_n = 1;
        set_fwd(0, 0, 0, 0, 0); rd2_reg = 32'h3C; alu_sel_rs2 = 0;
        @(negedge clk);
        chk("post_rst_op_b", op_b, 32'h3C);
        chk("post_rst_valid", {31'b0, out_valid}, 32'd1);
        step();

        set_idle();
        repeat (3) step();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
